// File: rtl/modbus_pkg.sv
// modbus_pkg: shared Modbus exception codes and holding-register FSM state encoding
// Contents: EXC_NONE/EXC_ILL_ADDR/EXC_ILL_VAL exception codes, state_t and S_* FSM states.
package modbus_pkg;
  localparam logic [7:0] EXC_NONE     = 8'h00;
  localparam logic [7:0] EXC_ILL_ADDR = 8'h02;
  localparam logic [7:0] EXC_ILL_VAL  = 8'h03;
  typedef logic [2:0] state_t;
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CHECK    = 3'd1;
  localparam logic [2:0] S_LOAD     = 3'd2;
  localparam logic [2:0] S_WAIT_CMT = 3'd3;
  localparam logic [2:0] S_COMMIT   = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
endpackage

// File: rtl/modbus_hreg_bank_if.sv
// modbus_hreg_bank_if: write-transaction, status and read bus of the holding-register bank
// Signals: wr_start/wr_addr/wr_qty open a write; wr_vld/wr_data/wr_rdy stream its words;
//   commit/abort close it; wr_done/wr_exc report completion; rd_req/rd_addr ask for a read
//   answered by rd_vld/rd_data/rd_err one cycle later.
// Modports: master drives requests (host side), slave is the register bank.
interface modbus_hreg_bank_if;
  logic        wr_start;
  logic [15:0] wr_addr;
  logic [7:0]  wr_qty;
  logic        wr_vld;
  logic [15:0] wr_data;
  logic        wr_rdy;
  logic        commit;
  logic        abort;
  logic        wr_done;
  logic [7:0]  wr_exc;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic [15:0] rd_data;
  logic        rd_vld;
  logic        rd_err;
  modport master (
    output wr_start, wr_addr, wr_qty, wr_vld, wr_data, commit, abort, rd_req, rd_addr,
    input  wr_rdy, wr_done, wr_exc, rd_data, rd_vld, rd_err
  );
  modport slave (
    input  wr_start, wr_addr, wr_qty, wr_vld, wr_data, commit, abort, rd_req, rd_addr,
    output wr_rdy, wr_done, wr_exc, rd_data, rd_vld, rd_err
  );
endinterface

// File: rtl/modbus_shadow_buf.sv
// modbus_shadow_buf: DEPTH x 16 staging buffer holding a write burst until it is committed
// Ports: clk; we/waddr/wdata synchronous write port; raddr/rdata combinational indexed read.
module modbus_shadow_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);
  logic [15:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/modbus_hreg_bank.sv
// modbus_hreg_bank: Modbus holding-register bank with staged, commit-or-abort burst writes
// Ports: clk, rst_n (synchronous, active low); bus (modbus_hreg_bank_if.slave) carrying the
//   write transaction, status and read channels; reg_q flattened registers (reg i at
//   [16i+15:16i]); reg_update per-register one-cycle write strobe; wprot_mask per-register
//   write protect, present only when MODBUS_HREG_WPROT_EN is defined.
// Words are staged in a shadow buffer and copied into the registers one per cycle only
// after commit, so an aborted or reset transaction never leaves a partial write behind.
module modbus_hreg_bank
  import modbus_pkg::*;
#(
  parameter int          N_REG      = 16,
  parameter logic [15:0] START_ADDR = 16'h0000,
  parameter int          MAX_BURST  = 8,
  parameter logic [15:0] RST_VAL    = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  modbus_hreg_bank_if.slave    bus,
`ifdef MODBUS_HREG_WPROT_EN
  input  logic [N_REG-1:0]     wprot_mask,
`endif
  output logic [N_REG*16-1:0]  reg_q,
  output logic [N_REG-1:0]     reg_update
);
  localparam int IW = N_REG > 1 ? $clog2(N_REG) : 1;
  localparam int AW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  logic [2:0]       state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       qty_q, qty_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       exc_q, exc_d;
  logic [IW-1:0]    base_q, base_d;
  logic [15:0]      regs_q [N_REG];
  logic [15:0]      regs_d [N_REG];
  logic [N_REG-1:0] upd_q, upd_d;
  logic [15:0]      rd_data_q, rd_data_d;
  logic             rd_vld_q, rd_err_q;
  logic [16:0]      off, fin, rd_off;
  logic             bad_val, bad_addr, prot_hit, rd_in, accept, last;
  logic [IW-1:0]    widx;
  logic [15:0]      sh_rdata;
  modbus_shadow_buf #(.DEPTH(MAX_BURST)) u_shadow (
    .clk   (clk),
    .we    (accept),
    .waddr (AW'(cnt_q)),
    .wdata (bus.wr_data),
    .raddr (AW'(cnt_q)),
    .rdata (sh_rdata)
  );
  // Range checks in 17 bits so an address near 16'hFFFF plus qty cannot wrap into range.
  always_comb begin
    off      = {1'b0, addr_q} - {1'b0, START_ADDR};
    fin      = off + {9'b0, qty_q};
    bad_val  = qty_q == 8'd0 || 32'(qty_q) > MAX_BURST;
    bad_addr = addr_q < START_ADDR || fin > 17'(N_REG);
    prot_hit = 1'b0;
`ifdef MODBUS_HREG_WPROT_EN
    for (int i = 0; i < N_REG; i++)
      prot_hit = prot_hit | (wprot_mask[i] && 17'(i) >= off && 17'(i) < fin);
`endif
    accept    = state_q == S_LOAD && bus.wr_vld && !bus.abort;
    last      = cnt_q + 8'd1 == qty_q;
    widx      = base_q + IW'(cnt_q);
    rd_off    = {1'b0, bus.rd_addr} - {1'b0, START_ADDR};
    rd_in     = bus.rd_addr >= START_ADDR && rd_off < 17'(N_REG);
    rd_data_d = bus.rd_req && rd_in ? regs_q[rd_off[IW-1:0]] : 16'h0000;
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    qty_d   = qty_q;
    cnt_d   = cnt_q;
    exc_d   = exc_q;
    base_d  = base_q;
    regs_d  = regs_q;
    upd_d   = '0;
    case (state_q)
      S_IDLE:
        if (bus.wr_start) begin
          state_d = S_CHECK;
          addr_d  = bus.wr_addr;
          qty_d   = bus.wr_qty;
        end
      S_CHECK: begin
        exc_d   = bad_val ? EXC_ILL_VAL : (bad_addr || prot_hit) ? EXC_ILL_ADDR : EXC_NONE;
        state_d = bad_val || bad_addr || prot_hit ? S_DONE : S_LOAD;
        base_d  = off[IW-1:0];
        cnt_d   = 8'd0;
      end
      S_LOAD:
        if (bus.abort) state_d = S_IDLE;
        else if (bus.wr_vld) begin
          cnt_d   = last ? 8'd0 : cnt_q + 8'd1;
          state_d = last ? S_WAIT_CMT : S_LOAD;
        end
      S_WAIT_CMT: state_d = bus.abort ? S_IDLE : bus.commit ? S_COMMIT : S_WAIT_CMT;
      S_COMMIT: begin
        regs_d[widx] = sh_rdata;
        upd_d[widx]  = 1'b1;
        cnt_d        = cnt_q + 8'd1;
        state_d      = last ? S_DONE : S_COMMIT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      qty_q     <= '0;
      cnt_q     <= '0;
      exc_q     <= EXC_NONE;
      base_q    <= '0;
      regs_q    <= '{default: RST_VAL};
      upd_q     <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      qty_q     <= qty_d;
      cnt_q     <= cnt_d;
      exc_q     <= exc_d;
      base_q    <= base_d;
      regs_q    <= regs_d;
      upd_q     <= upd_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= bus.rd_req;
      rd_err_q  <= bus.rd_req && !rd_in;
    end
  assign bus.wr_rdy  = state_q == S_LOAD;
  assign bus.wr_done = state_q == S_DONE;
  assign bus.wr_exc  = state_q == S_DONE ? exc_q : EXC_NONE;
  assign bus.rd_data = rd_data_q;
  assign bus.rd_vld  = rd_vld_q;
  assign bus.rd_err  = rd_err_q;
  assign reg_update  = upd_q;
  for (genvar g = 0; g < N_REG; g++) begin : g_out
    assign reg_q[16*g +: 16] = regs_q[g];
  end
endmodule

// File: tb/tb_modbus_hreg_bank.sv
// tb_modbus_hreg_bank: randomized self-checking bench for modbus_hreg_bank against an array model
module tb_modbus_hreg_bank;
  import modbus_pkg::*;
  localparam int          N     = 16;
  localparam int          MAXB  = 8;
  localparam int          START = 0;
  localparam logic [15:0] RV    = 16'h0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N*16-1:0] reg_q;
  logic [N-1:0]    reg_update;
`ifdef MODBUS_HREG_WPROT_EN
  logic [N-1:0]    wprot_mask = '0;
`endif
  logic [15:0] m [N];
  logic [15:0] wbuf [MAXB];
  bit          rd_same = 1'b0;
  int compared = 0, mismatched = 0;
  modbus_hreg_bank_if bus();
  modbus_hreg_bank #(.N_REG(N), .START_ADDR(16'(START)), .MAX_BURST(MAXB), .RST_VAL(RV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
`ifdef MODBUS_HREG_WPROT_EN
    .wprot_mask (wprot_mask),
`endif
    .reg_q      (reg_q),
    .reg_update (reg_update)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_regs(input string tag);
    for (int i = 0; i < N; i++) chk(tag, 32'(reg_q[16*i +: 16]), 32'(m[i]));
  endtask
  function automatic logic [16:0] model_rd(input logic [15:0] a);
    int o;
    o = int'(a) - START;
    return (o >= 0 && o < N) ? {1'b0, m[o]} : {1'b1, 16'h0000};
  endfunction
  function automatic logic [7:0] model_exc(input logic [15:0] a, input logic [7:0] q);
    int lo, hi;
    lo = int'(a) - START;
    hi = lo + int'(q);
    if (q == 8'd0 || int'(q) > MAXB) return EXC_ILL_VAL;
    if (lo < 0 || hi > N) return EXC_ILL_ADDR;
`ifdef MODBUS_HREG_WPROT_EN
    for (int i = lo; i < hi; i++) if (wprot_mask[i]) return EXC_ILL_ADDR;
`endif
    return EXC_NONE;
  endfunction
  task automatic rd_chk(input logic [15:0] a);
    logic [16:0] e;
    e = model_rd(a);
    bus.rd_req = 1'b1;
    bus.rd_addr = a;
    @(negedge clk);
    bus.rd_req = 1'b0;
    chk("rd_vld", 32'(bus.rd_vld), 32'd1);
    chk("rd_err", 32'(bus.rd_err), 32'(e[16]));
    chk("rd_data", 32'(bus.rd_data), 32'(e[15:0]));
  endtask
  task automatic wait_quiet(input string tag, input int n);
    repeat (n) begin
      @(negedge clk);
      chk({tag, "_done"}, 32'(bus.wr_done), 32'd0);
      chk({tag, "_upd"}, 32'(reg_update), 32'd0);
    end
    chk_regs({tag, "_regs"});
  endtask
  // act: 0 commit, 1 abort while waiting, 2 commit+abort together, 3 abort mid-load,
  // 4 reset during the commit phase
  task automatic do_write(input logic [15:0] a, input logic [7:0] q, input int act);
    logic [7:0]  ee;
    logic [16:0] er;
    logic [15:0] ra;
    logic [N-1:0] eu;
    int base;
    ee = model_exc(a, q);
    base = int'(a) - START;
    bus.wr_start = 1'b1;
    bus.wr_addr = a;
    bus.wr_qty = q;
    @(negedge clk);
    bus.wr_start = 1'b0;
    chk("check_rdy", 32'(bus.wr_rdy), 32'd0);
    chk("check_done", 32'(bus.wr_done), 32'd0);
    @(negedge clk);
    if (ee != EXC_NONE) begin
      chk("err_done", 32'(bus.wr_done), 32'd1);
      chk("err_exc", 32'(bus.wr_exc), 32'(ee));
      chk("err_rdy", 32'(bus.wr_rdy), 32'd0);
      @(negedge clk);
      chk("err_done_clr", 32'(bus.wr_done), 32'd0);
      chk("err_rdy_after", 32'(bus.wr_rdy), 32'd0);
      chk_regs("err_regs");
      return;
    end
    for (int i = 0; i < int'(q); i++) begin
      chk("load_rdy", 32'(bus.wr_rdy), 32'd1);
      if (act == 3 && i == 1) begin
        bus.abort = 1'b1;
        bus.commit = 1'($urandom_range(1));
        @(negedge clk);
        bus.abort = 1'b0;
        bus.commit = 1'b0;
        chk("abort_load_rdy", 32'(bus.wr_rdy), 32'd0);
        wait_quiet("abort_load", int'(q) + 2);
        return;
      end
      if ($urandom_range(2) == 0) begin
        bus.wr_vld = 1'b0;
        bus.wr_start = 1'($urandom_range(1));
        bus.wr_addr = 16'($urandom);
        @(negedge clk);
        chk("gap_rdy", 32'(bus.wr_rdy), 32'd1);
      end
      bus.wr_vld = 1'b1;
      bus.wr_data = wbuf[i];
      bus.wr_start = 1'($urandom_range(1));
      @(negedge clk);
      bus.wr_vld = 1'b0;
      bus.wr_start = 1'b0;
    end
    chk("wait_rdy", 32'(bus.wr_rdy), 32'd0);
    repeat ($urandom_range(2)) begin
      @(negedge clk);
      chk("wait_done", 32'(bus.wr_done), 32'd0);
      chk("wait_upd", 32'(reg_update), 32'd0);
    end
    if (act == 1 || act == 2) begin
      bus.abort = 1'b1;
      bus.commit = act == 2;
      @(negedge clk);
      bus.abort = 1'b0;
      bus.commit = 1'b0;
      wait_quiet("abort_wait", int'(q) + 2);
      return;
    end
    bus.commit = 1'b1;
    @(negedge clk);
    bus.commit = 1'b0;
    for (int i = 0; i < int'(q); i++) begin
      if (act == 4 && i == 2) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) m[k] = RV;
        chk_regs("rst_regs");
        chk("rst_upd", 32'(reg_update), 32'd0);
        chk("rst_rdy", 32'(bus.wr_rdy), 32'd0);
        chk("rst_done", 32'(bus.wr_done), 32'd0);
        chk("rst_exc", 32'(bus.wr_exc), 32'd0);
        chk("rst_rd_vld", 32'(bus.rd_vld), 32'd0);
        wait_quiet("rst_after", 4);
        return;
      end
      ra = (rd_same || $urandom_range(1) == 1) ? a + 16'(i) : 16'($urandom_range(N + 3));
      er = model_rd(ra);
      bus.rd_req = 1'b1;
      bus.rd_addr = ra;
      @(negedge clk);
      bus.rd_req = 1'b0;
      m[base + i] = wbuf[i];
      eu = '0;
      eu[base + i] = 1'b1;
      chk("cmt_upd", 32'(reg_update), 32'(eu));
      chk("cmt_reg", 32'(reg_q[16*(base + i) +: 16]), 32'(wbuf[i]));
      chk("cmt_rd_vld", 32'(bus.rd_vld), 32'd1);
      chk("cmt_rd_err", 32'(bus.rd_err), 32'(er[16]));
      chk("cmt_rd_old", 32'(bus.rd_data), 32'(er[15:0]));
      chk("cmt_done", 32'(bus.wr_done), 32'(i == int'(q) - 1));
      if (i == int'(q) - 1) chk("cmt_exc", 32'(bus.wr_exc), 32'(EXC_NONE));
    end
    @(negedge clk);
    chk("done_clr", 32'(bus.wr_done), 32'd0);
    chk("upd_clr", 32'(reg_update), 32'd0);
    chk_regs("cmt_regs");
  endtask
  initial begin
    bus.wr_start = 1'b0;
    bus.wr_addr = '0;
    bus.wr_qty = '0;
    bus.wr_vld = 1'b0;
    bus.wr_data = '0;
    bus.commit = 1'b0;
    bus.abort = 1'b0;
    bus.rd_req = 1'b0;
    bus.rd_addr = '0;
    for (int k = 0; k < N; k++) m[k] = RV;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_regs("reset_regs");
    chk("reset_rdy", 32'(bus.wr_rdy), 32'd0);
    chk("reset_done", 32'(bus.wr_done), 32'd0);
    chk("reset_exc", 32'(bus.wr_exc), 32'd0);
    chk("reset_rd_vld", 32'(bus.rd_vld), 32'd0);
    chk("reset_rd_err", 32'(bus.rd_err), 32'd0);
    chk("reset_rd_data", 32'(bus.rd_data), 32'd0);
    chk("reset_upd", 32'(reg_update), 32'd0);
    wbuf[0] = 16'h1111;
    wbuf[1] = 16'h2222;
    wbuf[2] = 16'h3333;
    rd_same = 1'b1;
    do_write(16'h0002, 8'd3, 0);
    rd_same = 1'b0;
    do_write(16'h000F, 8'd2, 0);
    do_write(16'h0000, 8'd0, 0);
    do_write(16'h0000, 8'd9, 0);
    do_write(16'hFFFF, 8'd8, 0);
    wbuf[0] = 16'hAAAA;
    wbuf[1] = 16'h5555;
    do_write(16'h0005, 8'd2, 2);
    do_write(16'h0003, 8'd1, 0);
    rd_chk(16'h0010);
    rd_chk(16'h0003);
    for (int i = 0; i < MAXB; i++) wbuf[i] = 16'(16'hC000 + i);
    do_write(16'h0008, 8'd4, 4);
    do_write(16'h0008, 8'd8, 0);
`ifdef MODBUS_HREG_WPROT_EN
    wprot_mask[5] = 1'b1;
    do_write(16'h0004, 8'd3, 0);
    wprot_mask = '0;
`endif
    for (int t = 0; t < 60; t++) begin
      logic [15:0] a;
      logic [7:0] q;
      int act;
      a = 16'($urandom_range(18));
      q = 8'($urandom_range(10));
      act = (q >= 8'd2 && $urandom_range(3) == 0) ? 3 : int'($urandom_range(2));
      for (int i = 0; i < MAXB; i++) wbuf[i] = 16'($urandom);
      do_write(a, q, act);
      rd_chk(16'($urandom_range(N + 2)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/modbus_hreg_bank.md
MODBUS_HREG_BANK -- requirements
Module: modbus_hreg_bank

Interface
REQ-001 SHALL have parameter N_REG, default 16, the number of holding registers (1..256).
REQ-002 SHALL have parameter START_ADDR, default 16'h0000, the Modbus address of register 0.
REQ-003 SHALL have parameter MAX_BURST, default 8, the maximum words per write transaction (1..123).
REQ-004 SHALL have parameter RST_VAL, default 16'h0000, the reset value of every register.
REQ-005 SHALL have ports: clk in 1, system clock; rst_n in 1, synchronous active-low reset.
REQ-006 SHALL have write-control ports: wr_start in 1, open transaction; wr_addr in 16, first Modbus address; wr_qty in 8, word count.
REQ-007 SHALL have write-data ports: wr_vld in 1, data valid; wr_data in 16, data word; wr_rdy out 1, bank accepts data.
REQ-008 SHALL have transaction ports: commit in 1, CRC-OK commit; abort in 1, discard transaction.
REQ-009 SHALL have status ports: wr_done out 1, one-cycle completion strobe; wr_exc out 8, Modbus exception code valid with wr_done.
REQ-010 SHALL have read ports: rd_req in 1, read request; rd_addr in 16, Modbus address; rd_data out 16, read word; rd_vld out 1, read result strobe; rd_err out 1, read address out of range.
REQ-011 SHALL have register outputs: reg_q out N_REG*16, flattened registers, reg i at bits [16i+15:16i]; reg_update out N_REG, per-register one-cycle write strobe.
REQ-012 SHALL have port wprot_mask in N_REG, per-register write protect, present only under MODBUS_HREG_WPROT_EN.

Function
REQ-013 SHALL run an FSM with states IDLE, CHECK, LOAD, WAIT_CMT, COMMIT, DONE.
REQ-014 SHALL, in IDLE on wr_start, latch wr_addr/wr_qty and go to CHECK; wr_start SHALL be ignored in every other state.
REQ-015 SHALL, in CHECK (one cycle), set exc 8'h03 when qty==0 or qty>MAX_BURST, else 8'h02 when addr<START_ADDR or (addr-START_ADDR)+qty>N_REG, then go to DONE; otherwise go to LOAD.
REQ-016 SHALL compute all range arithmetic in 17 bits so that addr+qty beyond 16'hFFFF yields 8'h02, never wrap-around acceptance.
REQ-017 SHALL assert wr_rdy only in LOAD; a word SHALL be accepted when wr_vld&&wr_rdy and stored in shadow slot cnt; after the qty-th word the FSM SHALL go to WAIT_CMT.
REQ-018 SHALL make wr_rdy high exactly 2 cycles after the wr_start cycle.
REQ-019 SHALL, in WAIT_CMT on commit, go to COMMIT; on abort, go to IDLE with no register change and no wr_done.
REQ-020 SHALL let abort in LOAD discard the transaction and return to IDLE; abort SHALL win over a simultaneous commit.
REQ-021 SHALL, in COMMIT, write one shadow word per cycle in ascending address order, pulse reg_update[i] in the same cycle reg_q slice i changes, and go to DONE after the last word.
REQ-022 SHALL, in DONE, pulse wr_done for one cycle with wr_exc (8'h00 on success), then return to IDLE.
REQ-023 SHALL give FC06 single writes as qty=1 with no special path.
REQ-024 SHALL serve reads independently of the FSM: rd_vld 1 cycle after rd_req; rd_data SHALL be the register value, or 16'h0000 with rd_err=1 if out of range.
REQ-025 SHALL return the pre-write value for a read coinciding with a COMMIT write to the same register.

Reset
REQ-026 SHALL, on rst_n low at a clk edge, set: all registers RST_VAL; FSM IDLE; wr_rdy, wr_done, rd_vld, rd_err, reg_update 0; wr_exc 8'h00; rd_data 16'h0000.
REQ-027 SHALL discard any in-flight transaction on reset mid-operation, leaving no partial commit visible.

Configuration
REQ-028 SHALL, with MODBUS_HREG_WPROT_EN defined, make CHECK return 8'h02 when any addressed register has wprot_mask set, with no register written.
REQ-029 SHALL, without MODBUS_HREG_WPROT_EN, omit the wprot_mask port and leave all registers writable.

Structure
REQ-030 SHALL place exception codes EXC_NONE=8'h00, EXC_ILL_ADDR=8'h02, EXC_ILL_VAL=8'h03 and the FSM state encoding in shared package modbus_pkg.
REQ-031 SHALL implement the MAX_BURST x 16 shadow buffer (write port, indexed read) as sub-module modbus_shadow_buf.

Verification
REQ-032 SHALL cover: wr_start addr=0x0002 qty=3, words 0x1111/0x2222/0x3333, commit -> regs 2..4 updated in 3 consecutive cycles, reg_update pulses, wr_done with wr_exc=0x00.
REQ-033 SHALL cover: addr=0x000F qty=2 (N_REG=16) -> wr_done with 0x02, wr_rdy never high; qty=0 and qty=9 -> 0x03.
REQ-034 SHALL cover: 2-word load, then commit and abort in the same cycle -> IDLE, no writes, no wr_done.
REQ-035 SHALL cover: rd_req addr 0x0003 in the commit-write cycle of reg 3 -> old value returned; rd_addr=0x0010 -> rd_err=1, rd_data=0.
REQ-036 SHALL cover: rst_n low during COMMIT of a 4-word write -> all regs RST_VAL, FSM IDLE.
REQ-037 SHALL cover, with MODBUS_HREG_WPROT_EN: wprot_mask bit 5 set, write addr 4 qty 3 -> 0x02, regs 4..6 unchanged.
